tlut_prod_drain: RTL and testbench

- Downstream of the SIMD temporal-LUT cell. Samples the cell's product register array once per completed rollover window.
- Accumulates the samples across DIM_B windows to cover the reduction tiles of the K dimension.
- Hands each finished DIM_C x DIM_A result tile to a double-buffered drain. The drain streams the tile out one weight row (DIM_A values) per valid/ready beat.

---
 rtl/tlut_prod_drain.sv | 139 +++++++++++++
 tb/tb_tlut_prod_drain.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlut_prod_drain.sv
// Accumulates SIMD temporal-LUT product windows into result tiles and drains each
// tile row by row over a valid/ready interface. Optional macro: TLUT_DRAIN_SAT_EN.
module tlut_prod_drain #(
   parameter int DIM_A     = 4,
   parameter int DIM_C     = 4,
   parameter int ACC_WIDTH = 12,
   parameter int DIM_B     = 4,
   parameter int OUT_WIDTH = 14,
   localparam int ROW_W    = (DIM_C > 1) ? $clog2(DIM_C) : 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       window_done,
   input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] product_in,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [DIM_A-1:0][OUT_WIDTH-1:0]            out_data,
   output logic [ROW_W-1:0]                           out_row,
   output logic                                       out_last,
   output logic                                       tile_busy,
   output logic                                       overrun
);

   localparam int WIN_W = (DIM_B > 1) ? $clog2(DIM_B) : 1;
   localparam int SUM_W = ACC_WIDTH + $clog2(DIM_B) + 1;
   localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(DIM_B - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM_C - 1);
   localparam logic [SUM_W-1:0] OUT_MAX  = {{(SUM_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   typedef enum logic {IDLE, DRAIN} state_t;

   logic [DIM_C-1:0][DIM_A-1:0][SUM_W-1:0]     acc_q, acc_d, sum;
   logic [DIM_C-1:0][DIM_A-1:0][OUT_WIDTH-1:0] buf_q, buf_d, sum_red;
   logic [WIN_W-1:0]                           win_cnt_q, win_cnt_d;
   state_t                                     state_q, state_d;
   logic [ROW_W-1:0]                           row_q, row_d, row_nxt;
   logic                                       out_valid_q, out_valid_d;
   logic [DIM_A-1:0][OUT_WIDTH-1:0]            out_data_q, out_data_d;
   logic                                       out_last_q, out_last_d;
   logic                                       tile_busy_q, tile_busy_d;
   logic                                       overrun_q, overrun_d;
   logic                                       tile_done, handshake, last_hs, drain_free, load;

   // The first window of a tile ignores stale accumulator contents, so no clear cycle is needed.
   always_comb begin
      for (int c = 0; c < DIM_C; c++) begin
         for (int a = 0; a < DIM_A; a++) begin
            sum[c][a] = ((win_cnt_q == '0) ? '0 : acc_q[c][a]) + SUM_W'(product_in[c][a]);
`ifdef TLUT_DRAIN_SAT_EN
            sum_red[c][a] = (sum[c][a] > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0] : sum[c][a][OUT_WIDTH-1:0];
`else
            sum_red[c][a] = sum[c][a][OUT_WIDTH-1:0];
`endif
         end
      end
   end

   always_comb begin
      tile_done  = window_done && (win_cnt_q == LAST_WIN);
      handshake  = out_valid_q && out_ready;
      last_hs    = handshake && (row_q == LAST_ROW);
      // A tile finishing on the same cycle the last row leaves sees the drain as free.
      drain_free = (state_q == IDLE) || last_hs;
      load       = tile_done && drain_free;
      row_nxt    = row_q + ROW_W'(1);

      acc_d       = acc_q;
      win_cnt_d   = win_cnt_q;
      buf_d       = buf_q;
      state_d     = state_q;
      row_d       = row_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      tile_busy_d = tile_busy_q;
      overrun_d   = overrun_q || (tile_done && !drain_free);

      if (window_done) begin
         acc_d     = sum;
         win_cnt_d = tile_done ? '0 : win_cnt_q + WIN_W'(1);
      end

      if (load) begin
         buf_d       = sum_red;
         state_d     = DRAIN;
         row_d       = '0;
         out_valid_d = 1'b1;
         out_data_d  = sum_red[0];
         out_last_d  = (DIM_C == 1);
         tile_busy_d = 1'b1;
      end else if (state_q == DRAIN && handshake) begin
         if (last_hs) begin
            state_d     = IDLE;
            row_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            tile_busy_d = 1'b0;
         end else begin
            row_d      = row_nxt;
            out_data_d = buf_q[row_nxt];
            out_last_d = (row_nxt == LAST_ROW);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         win_cnt_q   <= '0;
         buf_q       <= '0;
         state_q     <= IDLE;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         tile_busy_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         win_cnt_q   <= win_cnt_d;
         buf_q       <= buf_d;
         state_q     <= state_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         tile_busy_q <= tile_busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = row_q;
   assign out_last  = out_last_q;
   assign tile_busy = tile_busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_tlut_prod_drain.sv
// Directed self-checking bench for tlut_prod_drain; a second instance with
// OUT_WIDTH=12 exercises the saturate/truncate reduction.
module tb_tlut_prod_drain;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        window_done;
   logic [3:0][3:0][11:0]       product_in;
   logic                        out_ready;
   logic                        out_valid, out_last, tile_busy, overrun;
   logic [3:0][13:0]            out_data;
   logic [1:0]                  out_row;
   logic                        o12_valid, o12_last, o12_busy, o12_overrun;
   logic [3:0][11:0]            o12_data;
   logic [1:0]                  o12_row;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tlut_prod_drain dut (
      .clk(clk), .rst(rst), .window_done(window_done), .product_in(product_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_last(out_last), .tile_busy(tile_busy), .overrun(overrun)
   );

   tlut_prod_drain #(.OUT_WIDTH(12)) dut12 (
      .clk(clk), .rst(rst), .window_done(window_done), .product_in(product_in),
      .out_valid(o12_valid), .out_ready(out_ready), .out_data(o12_data),
      .out_row(o12_row), .out_last(o12_last), .tile_busy(o12_busy), .overrun(o12_overrun)
   );

   // mode 0: every product = val; mode 1: k*1000 + c*10 + a
   task set_prod(input int mode, input int k, input int val);
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < 4; a++)
            product_in[c][a] = (mode == 0) ? 12'(val) : 12'(k*1000 + c*10 + a);
   endtask

   task do_reset();
      rst = 1'b1; window_done = 1'b0; out_ready = 1'b0; set_prod(0, 0, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task test_reset();
      do_reset();
      n_checks++;
      if ({out_valid, out_last, tile_busy, overrun} !== 4'b0000) begin
         $display("[TB] FAIL reset_flags got %b want 0000", {out_valid, out_last, tile_busy, overrun}); n_fail++;
      end
      n_checks++;
      if (out_data !== '0 || out_row !== 2'd0) begin
         $display("[TB] FAIL reset_data got data=%h row=%0d want 0/0", out_data, out_row); n_fail++;
      end
   endtask

   task test_constant();
      set_prod(0, 0, 100); out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         if (w == 3) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               $display("[TB] FAIL const_early_valid got %b want 0", out_valid); n_fail++;
            end
         end
         window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      for (int r = 0; r < 4; r++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_row !== 2'(r) || out_last !== (r == 3) || tile_busy !== 1'b1) begin
            $display("[TB] FAIL const_ctl row%0d got v=%b row=%0d last=%b busy=%b want 1/%0d/%0d/1",
                     r, out_valid, out_row, out_last, tile_busy, r, r == 3); n_fail++;
         end
         for (int a = 0; a < 4; a++) begin
            n_checks++;
            if (out_data[a] !== 14'd400) begin
               $display("[TB] FAIL const_data r%0d a%0d got %0d want 400", r, a, out_data[a]); n_fail++;
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (out_valid !== 1'b0 || tile_busy !== 1'b0 || overrun !== 1'b0) begin
         $display("[TB] FAIL const_end got v=%b busy=%b ovr=%b want 0/0/0", out_valid, tile_busy, overrun); n_fail++;
      end
   endtask

   task test_pattern();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); set_prod(1, k, 0); window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 4; a++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data[a] !== 14'(6000 + 40*r + 4*a)) begin
               $display("[TB] FAIL pattern r%0d a%0d got v=%b d=%0d want 1/%0d", r, a, out_valid, out_data[a], 6000 + 40*r + 4*a); n_fail++;
            end
         end
         @(negedge clk);
      end
   endtask

   task test_backpressure();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); set_prod(1, k, 0); window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      @(negedge clk); out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_row !== 2'd1 || out_data[3] !== 14'(6052) || out_data[0] !== 14'(6040)) begin
            $display("[TB] FAIL bp_hold cyc%0d got v=%b row=%0d d0=%0d d3=%0d want 1/1/6040/6052",
                     i, out_valid, out_row, out_data[0], out_data[3]); n_fail++;
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_row !== 2'd2 || out_data[1] !== 14'(6084)) begin
         $display("[TB] FAIL bp_resume got v=%b row=%0d d1=%0d want 1/2/6084", out_valid, out_row, out_data[1]); n_fail++;
      end
      @(negedge clk); @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("[TB] FAIL bp_end got v=%b want 0", out_valid); n_fail++;
      end
   endtask

   task test_back_to_back();
      out_ready = 1'b1; set_prod(0, 0, 100);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 4) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_row !== 2'(i-4) || out_data[2] !== 14'd400) begin
               $display("[TB] FAIL b2b_a row%0d got v=%b row=%0d d=%0d want 1/%0d/400", i-4, out_valid, out_row, out_data[2], i-4); n_fail++;
            end
         end
         if (i == 4) set_prod(0, 0, 50);
         window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_row !== 2'd0 || out_data[0] !== 14'd200 || overrun !== 1'b0) begin
         $display("[TB] FAIL b2b_b got v=%b row=%0d d=%0d ovr=%b want 1/0/200/0", out_valid, out_row, out_data[0], overrun); n_fail++;
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || overrun !== 1'b0) begin
         $display("[TB] FAIL b2b_end got v=%b ovr=%b want 0/0", out_valid, overrun); n_fail++;
      end
   endtask

   task test_overrun();
      out_ready = 1'b0; set_prod(0, 0, 100);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 4) set_prod(0, 0, 7);
         window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      n_checks++;
      if (overrun !== 1'b1 || out_row !== 2'd0) begin
         $display("[TB] FAIL ovr_flag got ovr=%b row=%0d want 1/0", overrun, out_row); n_fail++;
      end
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_row !== 2'(r) || out_data[r] !== 14'd400) begin
            $display("[TB] FAIL ovr_drain r%0d got v=%b row=%0d d=%0d want 1/%0d/400", r, out_valid, out_row, out_data[r], r); n_fail++;
         end
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (overrun !== 1'b1 || out_valid !== 1'b0) begin
         $display("[TB] FAIL ovr_sticky got ovr=%b v=%b want 1/0", overrun, out_valid); n_fail++;
      end
   endtask

   task test_sat_and_reset();
      logic [11:0] exp12;
`ifdef TLUT_DRAIN_SAT_EN
      exp12 = 12'd4095;
`else
      exp12 = 12'd4092;
`endif
      do_reset();
      out_ready = 1'b1; set_prod(0, 0, 4095);
      for (int w = 0; w < 4; w++) begin
         @(negedge clk); window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      for (int r = 0; r < 4; r++) begin
         n_checks++;
         if (o12_valid !== 1'b1 || o12_data[r] !== exp12 || out_data[r] !== 14'd16380) begin
            $display("[TB] FAIL sat r%0d got v=%b d12=%0d d14=%0d want 1/%0d/16380", r, o12_valid, o12_data[r], out_data[r], exp12); n_fail++;
         end
         @(negedge clk);
      end
      for (int w = 0; w < 4; w++) begin
         @(negedge clk); window_done = 1'b1;
      end
      @(negedge clk); window_done = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || tile_busy !== 1'b0 || out_row !== 2'd0) begin
         $display("[TB] FAIL rst_mid got v=%b busy=%b row=%0d want 0/0/0", out_valid, tile_busy, out_row); n_fail++;
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            $display("[TB] FAIL rst_after cyc%0d got v=%b want 0", i, out_valid); n_fail++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_pattern();
      test_backpressure();
      test_back_to_back();
      test_overrun();
      test_sat_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
